// File: rtl/render_pkg.sv
// render_pkg: shared widths, raster defaults, command record and sequencer states
package render_pkg;
  localparam int X_W = 11;
  localparam int Y_W = 12;
  localparam int COLOR_W = 32;
  localparam int PROG_W = 6;
  localparam int DEF_SCREEN_W = 1080;
  localparam int DEF_SCREEN_H = 2160;
  typedef struct packed {
    logic [PROG_W-1:0] id;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, PROG, SCAN} state_t;
endpackage

// File: rtl/render_cmd_fifo.sv
// render_cmd_fifo: first-word-fall-through command FIFO (DEPTH a power of two)
// Ports: push/wr_data write side (ignored while full), pop/rd_data read side
// (ignored while empty), full/empty/count registered status.
module render_cmd_fifo #(
  parameter int W = $bits(render_pkg::cmd_t),
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count, w_count_nxt;
  logic r_full, r_empty, w_push, w_pop;
  always_comb begin
    w_push = push && !r_full;
    w_pop = pop && !r_empty;
    w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end
  // Flags are registered from the next count so they never lag the data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full <= w_count_nxt == (AW+1)'(DEPTH);
      r_empty <= w_count_nxt == '0;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= wr_data;
  assign rd_data = r_mem[r_rptr];
  assign full = r_full;
  assign empty = r_empty;
  assign count = r_count;
endmodule

// File: rtl/render_scan_sequencer.sv
// render_scan_sequencer: drains queued shape commands into the renderer chain, then scans the raster
// Ports: cmd_* host command write side (cmd_ready = FIFO not full); enable lets
// frames start; bg_color sampled at frame start; out_ready stalls the output bus
// program_out/x_out/y_out/color_out/shape_w_out/shape_h_out/out_valid with
// frame_start/frame_end pulses on the first/last pixel.
module render_scan_sequencer
  import render_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int CMD_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [PROG_W-1:0]  cmd_id,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic               out_ready,
  output logic [PROG_W-1:0]  program_out,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic [X_W-1:0]     shape_w_out,
  output logic [Y_W-1:0]     shape_h_out,
  output logic               out_valid,
  output logic               frame_start,
  output logic               frame_end
);
  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W-1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H-1);
  state_t r_state;
  logic r_valid, r_fs, r_fe;
  logic [PROG_W-1:0] r_prog;
  logic [X_W-1:0] r_x, r_w, w_nx;
  logic [Y_W-1:0] r_y, r_h, w_ny;
  logic [COLOR_W-1:0] r_color;
  cmd_t w_cmd, w_wr_cmd;
  logic w_full, w_empty, w_adv, w_pop, w_wrap;
  logic [$clog2(CMD_DEPTH):0] w_count;
  assign w_wr_cmd = '{id: cmd_id, x: cmd_x, y: cmd_y, color: cmd_color, w: cmd_w, h: cmd_h};
  // The output register doubles as the scan counter: the pixel on the bus is
  // the current position, so the next pixel derives from it.
  always_comb begin
    w_adv = !r_valid || out_ready;
    w_pop = r_state == PROG && w_adv && w_count != '0;
    w_wrap = r_x == X_MAX;
    w_nx = w_wrap ? '0 : r_x + X_W'(1);
    w_ny = w_wrap ? r_y + Y_W'(1) : r_y;
  end
  render_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(cmd_valid), .wr_data(w_wr_cmd), .pop(w_pop),
    .rd_data(w_cmd), .full(w_full), .empty(w_empty), .count(w_count)
  );
  // On an empty FIFO, PROG loads pixel (0,0) directly so the gap after the
  // last command (or after frame_end) is a single cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_prog <= '0;
      r_x <= '0;
      r_y <= '0;
      r_color <= '0;
      r_w <= '0;
      r_h <= '0;
      r_fs <= 1'b0;
      r_fe <= 1'b0;
    end else
      case (r_state)
        IDLE: if (enable) r_state <= PROG;
        PROG: if (w_adv) begin
          if (!w_empty) begin
            r_valid <= w_cmd.id != '0;
            r_prog <= w_cmd.id;
            r_x <= w_cmd.x;
            r_y <= w_cmd.y;
            r_color <= w_cmd.color;
            r_w <= w_cmd.w;
            r_h <= w_cmd.h;
          end else begin
            r_state <= SCAN;
            r_valid <= 1'b1;
            r_prog <= '0;
            r_x <= '0;
            r_y <= '0;
            r_color <= bg_color;
            r_w <= '0;
            r_h <= '0;
            r_fs <= 1'b1;
            r_fe <= X_MAX == '0 && Y_MAX == '0;
          end
        end
        SCAN: if (w_adv) begin
          r_fs <= 1'b0;
          if (r_fe) begin
            r_valid <= 1'b0;
            r_fe <= 1'b0;
            r_state <= enable ? PROG : IDLE;
          end else begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_fe <= w_nx == X_MAX && w_ny == Y_MAX;
          end
        end
        default: r_state <= IDLE;
      endcase
  assign cmd_ready = !w_full;
  assign program_out = r_prog;
  assign x_out = r_x;
  assign y_out = r_y;
  assign color_out = r_color;
  assign shape_w_out = r_w;
  assign shape_h_out = r_h;
  assign out_valid = r_valid;
  assign frame_start = r_fs;
  assign frame_end = r_fe;
endmodule

// File: tb/tb_render_scan_sequencer.sv
// tb_render_scan_sequencer: table-driven commands plus scoreboarded scan frames on a reduced raster
module tb_render_scan_sequencer;
  import render_pkg::*;
  localparam int W = 8;
  localparam int H = 4;
  typedef struct packed {
    logic [5:0] prog;
    logic [10:0] x;
    logic [11:0] y;
    logic [31:0] color;
    logic [10:0] w;
    logic [11:0] h;
    logic fs;
    logic fe;
  } beat_t;
  typedef struct {
    cmd_t c;
    bit emit;
  } vec_t;
  logic clk = 0, rst_n, enable, cmd_valid, cmd_ready, out_ready, out_valid, frame_start, frame_end;
  logic [31:0] bg_color, cmd_color, color_out;
  logic [5:0] cmd_id, program_out;
  logic [10:0] cmd_x, cmd_w, x_out, shape_w_out;
  logic [11:0] cmd_y, cmd_h, y_out, shape_h_out;
  render_scan_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .CMD_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bg_color(bg_color),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_x(cmd_x),
    .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .out_ready(out_ready), .program_out(program_out), .x_out(x_out), .y_out(y_out),
    .color_out(color_out), .shape_w_out(shape_w_out), .shape_h_out(shape_h_out),
    .out_valid(out_valid), .frame_start(frame_start), .frame_end(frame_end)
  );
  always #5 clk = ~clk;
  beat_t cur, p_beat, e_beat;
  beat_t q[$];
  vec_t tbl[12];
  logic p_stall = 0;
  int n_vec = 0, n_err = 0, cyc = 0, fe_cyc = 0, gap = -1;
  assign cur = {program_out, x_out, y_out, color_out, shape_w_out, shape_h_out, frame_start, frame_end};
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic beat_t pix(int px, int py, logic [31:0] bg);
    return '{prog: 6'd0, x: 11'(px), y: 12'(py), color: bg, w: 11'd0, h: 12'd0,
             fs: px == 0 && py == 0, fe: px == W-1 && py == H-1};
  endfunction
  function automatic beat_t cmd_beat(cmd_t c);
    return '{prog: c.id, x: c.x, y: c.y, color: c.color, w: c.w, h: c.h, fs: 1'b0, fe: 1'b0};
  endfunction
  task automatic exp_frame(logic [31:0] bg);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) q.push_back(pix(x, y, bg));
  endtask
  // Scoreboard: every accepted beat must match the queue head; a stalled
  // beat must be held unchanged into the next cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) p_stall = 1'b0;
    else begin
      if (p_stall) chk("hold", {out_valid, cur}, {1'b1, p_beat});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got %h, expected no output", cur);
        end else begin
          e_beat = q.pop_front();
          chk("beat", cur, e_beat);
        end
        if (frame_end) fe_cyc = cyc;
        if (frame_start) gap = cyc - fe_cyc;
      end
      p_stall = out_valid && !out_ready;
      p_beat = cur;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_cmd(cmd_t c);
    for (int i = 0; i < 100 && !cmd_ready; i++) tick;
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_id = c.id;
    cmd_x = c.x;
    cmd_y = c.y;
    cmd_color = c.color;
    cmd_w = c.w;
    cmd_h = c.h;
    tick;
    cmd_valid = 0;
  endtask
  task automatic apply(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      push_cmd(tbl[i].c);
      if (tbl[i].emit) q.push_back(cmd_beat(tbl[i].c));
    end
  endtask
  task automatic wait_pix(int px, int py);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid && program_out == 0 && x_out == 11'(px) && y_out == 12'(py);
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pix: pixel (%0d,%0d) not seen, expected within 300 cycles", px, py);
    end
  endtask
  task automatic wait_drain;
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    chk("drain_left", q.size(), 0);
    repeat (3) tick;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    tick;
  endtask
  task automatic pulse_enable;
    enable = 1;
    tick;
    enable = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{c: '{id: 6'd1, x: 11'd0, y: 12'd0, color: 32'hFF000000, w: 11'(W), h: 12'(H)}, emit: 1};
    tbl[1] = '{c: '{id: 6'd1, x: 11'd3, y: 12'd2, color: 32'h80FF0000, w: 11'd4, h: 12'd2}, emit: 1};
    tbl[2] = '{c: '{id: 6'd0, x: 11'd7, y: 12'd1, color: 32'h12345678, w: 11'd1, h: 12'd1}, emit: 0};
    tbl[3] = '{c: '{id: 6'd2, x: 11'd1, y: 12'd3, color: 32'h4000FF00, w: 11'd2, h: 12'd1}, emit: 1};
    for (int i = 4; i < 12; i++)
      tbl[i] = '{c: '{id: 6'(i - 3), x: 11'(i * 3), y: 12'(i * 5), color: $urandom, w: 11'(i), h: 12'(i + 1)}, emit: 1};
    rst_n = 0; enable = 0; cmd_valid = 0; out_ready = 1; bg_color = 0;
    cmd_id = 0; cmd_x = 0; cmd_y = 0; cmd_color = 0; cmd_w = 0; cmd_h = 0;
    @(negedge clk);
    chk("reset", {out_valid, cur, cmd_ready}, 1);
    tick;
    rst_n = 1;
    tick;
    bg_color = 32'h11223344;
    apply(0, 0);
    exp_frame(32'h11223344);
    pulse_enable;
    wait_drain;
    bg_color = 32'h00ABCDEF;
    apply(1, 3);
    exp_frame(32'h00ABCDEF);
    pulse_enable;
    wait_drain;
    bg_color = 32'h80808080;
    exp_frame(32'h80808080);
    enable = 1;
    wait_pix(0, 0);
    tick;
    apply(4, 11);
    chk("cmd_ready_full", cmd_ready, 0);
    exp_frame(32'h80808080);
    wait_pix(W-1, H-1);
    wait_pix(W-2, 0);
    tick;
    out_ready = 0;
    repeat (3) tick;
    out_ready = 1;
    wait_pix(0, 3);
    tick;
    enable = 0;
    wait_drain;
    chk("gap_8cmds", gap, 10);
    chk("cmd_ready_empty", cmd_ready, 1);
    bg_color = 32'h01020304;
    exp_frame(32'h01020304);
    pulse_enable;
    wait_pix(2, 1);
    tick;
    push_cmd(tbl[0].c);
    wait_pix(5, 2);
    tick;
    rst_n = 0;
    @(negedge clk);
    chk("reset_mid", {out_valid, cur, cmd_ready}, 1);
    tick;
    rst_n = 1;
    q.delete();
    tick;
    bg_color = 32'hDEADBEEF;
    exp_frame(32'hDEADBEEF);
    exp_frame(32'hDEADBEEF);
    enable = 1;
    wait_pix(W-1, H-1);
    wait_pix(0, 1);
    tick;
    enable = 0;
    wait_drain;
    chk("gap_empty", gap, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
